// File: rtl/regfile_pkg.sv
// Shared definitions for the scoreboarded register file: default geometry and
// the write-port select encoding used when decoding clears versus write-backs.
package regfile_pkg;

  localparam int unsigned DATA_W_DEF = 16;
  localparam int unsigned ADDR_W_DEF = 3;

  // Source selected for a register's next value (or for a bypassed read).
  typedef enum logic [1:0] {
    WSEL_HOLD  = 2'd0,
    WSEL_WRITE = 2'd1,
    WSEL_ZERO  = 2'd2
  } wsel_e;

  // Priority: clear-all, then single clear, then write-back.
  function automatic wsel_e wsel_decode(input logic clr_all,
                                        input logic clr_hit,
                                        input logic wr_hit);
    wsel_e sel;
    if (clr_all || clr_hit) begin
      sel = WSEL_ZERO;
    end else if (wr_hit) begin
      sel = WSEL_WRITE;
    end else begin
      sel = WSEL_HOLD;
    end
    return sel;
  endfunction

endpackage

// File: rtl/regfile_scoreboard.sv
// Busy-bit scoreboard: one pending flag per register plus a registered
// count of pending registers.
module regfile_scoreboard
  import regfile_pkg::*;
#(
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter bit          ZERO_R0 = 1'b0
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              iss_en_i,
  input  logic [ADDR_W-1:0] iss_addr_i,
  input  logic              wr_en_i,
  input  logic [ADDR_W-1:0] wr_addr_i,
  input  logic              clr_en_i,
  input  logic [ADDR_W-1:0] clr_addr_i,
  input  logic              clr_all_i,
  input  logic [ADDR_W-1:0] rd_addr_a_i,
  input  logic [ADDR_W-1:0] rd_addr_b_i,
  output logic              rd_busy_a_o,
  output logic              rd_busy_b_o,
  output logic [ADDR_W:0]   pend_cnt_o
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DEPTH-1:0] busy_q, busy_d;
  logic [ADDR_W:0]  pend_q, pend_d;

  // Next busy vector: clear-all, then issue (sets), then write-back/clear (resets).
  always_comb begin
    busy_d = busy_q;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (clr_all_i) begin
        busy_d[i] = 1'b0;
      end else if (iss_en_i && (iss_addr_i == ADDR_W'(i))) begin
        busy_d[i] = 1'b1;
      end else if ((wr_en_i && (wr_addr_i == ADDR_W'(i))) ||
                   (clr_en_i && (clr_addr_i == ADDR_W'(i)))) begin
        busy_d[i] = 1'b0;
      end
      if (ZERO_R0 && (i == 0)) begin
        busy_d[i] = 1'b0;
      end
    end
  end

  // Count is taken from the next-state vector so it is valid right after the edge.
  always_comb begin
    pend_d = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      pend_d = pend_d + {{ADDR_W{1'b0}}, busy_d[i]};
    end
  end

  // Busy vector and pending count registers.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      busy_q <= '0;
      pend_q <= '0;
    end else begin
      busy_q <= busy_d;
      pend_q <= pend_d;
    end
  end

  // Read view: a same-cycle write-back hides the busy bit unless re-issued.
  always_comb begin
    rd_busy_a_o = busy_q[rd_addr_a_i] &&
                  !(wr_en_i && (wr_addr_i == rd_addr_a_i) &&
                    !(iss_en_i && (iss_addr_i == rd_addr_a_i)));
    rd_busy_b_o = busy_q[rd_addr_b_i] &&
                  !(wr_en_i && (wr_addr_i == rd_addr_b_i) &&
                    !(iss_en_i && (iss_addr_i == rd_addr_b_i)));
    if (ZERO_R0 && (rd_addr_a_i == '0)) rd_busy_a_o = 1'b0;
    if (ZERO_R0 && (rd_addr_b_i == '0)) rd_busy_b_o = 1'b0;
  end

  assign pend_cnt_o = pend_q;

endmodule

// File: rtl/regfile_sb.sv
// Two-read, one-write register file with write-back bypass, single/all clear,
// and an issue scoreboard tracking registers with a pending result.
module regfile_sb
  import regfile_pkg::*;
#(
  parameter int unsigned DATA_W  = DATA_W_DEF,
  parameter int unsigned ADDR_W  = ADDR_W_DEF,
  parameter bit          ZERO_R0 = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [ADDR_W-1:0] rd_addr_a,
  input  logic [ADDR_W-1:0] rd_addr_b,
  output logic [DATA_W-1:0] rd_data_a,
  output logic [DATA_W-1:0] rd_data_b,
  output logic              rd_busy_a,
  output logic              rd_busy_b,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  input  logic              iss_en,
  input  logic [ADDR_W-1:0] iss_addr,
  input  logic              clr_en,
  input  logic [ADDR_W-1:0] clr_addr,
  input  logic              clr_all,
  output logic [ADDR_W:0]   pend_cnt
);

  localparam int unsigned DEPTH = 1 << ADDR_W;

  logic [DATA_W-1:0] regs_q [DEPTH];
  logic [DATA_W-1:0] regs_d [DEPTH];
  wsel_e             sel_a, sel_b;

  // Per-register next value from the clear/write priority decode.
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      regs_d[i] = regs_q[i];
      case (wsel_decode(clr_all,
                        clr_en && (clr_addr == ADDR_W'(i)),
                        wr_en && (wr_addr == ADDR_W'(i))))
        WSEL_ZERO:  regs_d[i] = '0;
        WSEL_WRITE: regs_d[i] = wr_data;
        default:    regs_d[i] = regs_q[i];
      endcase
      if (ZERO_R0 && (i == 0)) begin
        regs_d[i] = '0;
      end
    end
  end

  // Register array storage.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      for (int unsigned i = 0; i < DEPTH; i++) begin
        regs_q[i] <= regs_d[i];
      end
    end
  end

  // Read ports forward the value the addressed register takes at the next edge
  // (same decode as the array); reset and a hard-wired r0 force zero.
  always_comb begin
    sel_a = wsel_decode(clr_all, clr_en && (clr_addr == rd_addr_a),
                        wr_en && (wr_addr == rd_addr_a));
    sel_b = wsel_decode(clr_all, clr_en && (clr_addr == rd_addr_b),
                        wr_en && (wr_addr == rd_addr_b));
    case (sel_a)
      WSEL_ZERO:  rd_data_a = '0;
      WSEL_WRITE: rd_data_a = wr_data;
      default:    rd_data_a = regs_q[rd_addr_a];
    endcase
    case (sel_b)
      WSEL_ZERO:  rd_data_b = '0;
      WSEL_WRITE: rd_data_b = wr_data;
      default:    rd_data_b = regs_q[rd_addr_b];
    endcase
    if (rst || (ZERO_R0 && (rd_addr_a == '0))) rd_data_a = '0;
    if (rst || (ZERO_R0 && (rd_addr_b == '0))) rd_data_b = '0;
  end

  regfile_scoreboard #(
    .ADDR_W  (ADDR_W),
    .ZERO_R0 (ZERO_R0)
  ) u_scoreboard (
    .clk_i       (clk),
    .rst_i       (rst),
    .iss_en_i    (iss_en),
    .iss_addr_i  (iss_addr),
    .wr_en_i     (wr_en),
    .wr_addr_i   (wr_addr),
    .clr_en_i    (clr_en),
    .clr_addr_i  (clr_addr),
    .clr_all_i   (clr_all),
    .rd_addr_a_i (rd_addr_a),
    .rd_addr_b_i (rd_addr_b),
    .rd_busy_a_o (rd_busy_a),
    .rd_busy_b_o (rd_busy_b),
    .pend_cnt_o  (pend_cnt)
  );

endmodule

// File: tb/tb_regfile_sb.sv
// Bench for regfile_sb: a default build and a ZERO_R0 build share stimulus and
// are checked every cycle against an array model, plus directed literal cases.
module tb_regfile_sb;

  localparam int DW = 16;
  localparam int AW = 3;
  localparam int N  = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [AW-1:0] ra = '0, rb = '0, wa = '0, ia = '0, ca = '0;
  logic [DW-1:0] wd = '0;
  logic          we = 1'b0, ie = 1'b0, ce = 1'b0, call = 1'b0;

  logic [DW-1:0] rda [2];
  logic [DW-1:0] rdb [2];
  logic          rba [2];
  logic          rbb [2];
  logic [AW:0]   pc  [2];

  always #5 clk = ~clk;

  regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .ZERO_R0(1'b0)) dut0 (
    .clk(clk), .rst(rst), .rd_addr_a(ra), .rd_addr_b(rb),
    .rd_data_a(rda[0]), .rd_data_b(rdb[0]), .rd_busy_a(rba[0]), .rd_busy_b(rbb[0]),
    .wr_en(we), .wr_addr(wa), .wr_data(wd), .iss_en(ie), .iss_addr(ia),
    .clr_en(ce), .clr_addr(ca), .clr_all(call), .pend_cnt(pc[0]));

  regfile_sb #(.DATA_W(DW), .ADDR_W(AW), .ZERO_R0(1'b1)) dut1 (
    .clk(clk), .rst(rst), .rd_addr_a(ra), .rd_addr_b(rb),
    .rd_data_a(rda[1]), .rd_data_b(rdb[1]), .rd_busy_a(rba[1]), .rd_busy_b(rbb[1]),
    .wr_en(we), .wr_addr(wa), .wr_data(wd), .iss_en(ie), .iss_addr(ia),
    .clr_en(ce), .clr_addr(ca), .clr_all(call), .pend_cnt(pc[1]));

  int n_tests = 0;
  int n_fail  = 0;

  // Reference state: register contents and pending flags for each build.
  logic [DW-1:0] mreg  [2][N];
  logic          mbusy [2][N];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // Expected read data; valid=0 where a clear hits the address with no write to it.
  function automatic logic [DW-1:0] m_data(input int z, input logic [AW-1:0] a,
                                           output bit valid);
    bit whit, chit;
    valid = 1'b1;
    if (rst || (z == 1 && a == 0)) return '0;
    whit = we && (wa == a);
    chit = call || (ce && (ca == a));
    if (whit) return chit ? '0 : wd;
    if (chit) begin
      valid = 1'b0;
      return '0;
    end
    return mreg[z][a];
  endfunction

  function automatic logic m_busy(input int z, input logic [AW-1:0] a);
    if (rst || (z == 1 && a == 0)) return 1'b0;
    if (we && (wa == a) && !(ie && (ia == a))) return 1'b0;
    return mbusy[z][a];
  endfunction

  function automatic int m_pend(input int z);
    int c = 0;
    for (int i = 0; i < N; i++) c += int'(mbusy[z][i]);
    return c;
  endfunction

  // Model state update from the architectural rules.
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int z = 0; z < 2; z++)
        for (int i = 0; i < N; i++) begin
          mreg[z][i]  = '0;
          mbusy[z][i] = 1'b0;
        end
    end else begin
      for (int z = 0; z < 2; z++)
        for (int i = 0; i < N; i++) begin
          if (!(z == 1 && i == 0)) begin
            if (call || (ce && ca == AW'(i))) mreg[z][i] = '0;
            else if (we && wa == AW'(i))      mreg[z][i] = wd;
            if (call)                         mbusy[z][i] = 1'b0;
            else if (ie && ia == AW'(i))      mbusy[z][i] = 1'b1;
            else if ((we && wa == AW'(i)) || (ce && ca == AW'(i))) mbusy[z][i] = 1'b0;
          end
        end
    end
  end

  // Every-cycle compare of both builds against the model.
  always @(negedge clk) begin
    logic [DW-1:0] e;
    bit v;
    for (int z = 0; z < 2; z++) begin
      e = m_data(z, ra, v);
      if (v) chk($sformatf("dut%0d rd_data_a[%0d]", z, ra), 32'(rda[z]), 32'(e));
      e = m_data(z, rb, v);
      if (v) chk($sformatf("dut%0d rd_data_b[%0d]", z, rb), 32'(rdb[z]), 32'(e));
      chk($sformatf("dut%0d rd_busy_a[%0d]", z, ra), 32'(rba[z]), 32'(m_busy(z, ra)));
      chk($sformatf("dut%0d rd_busy_b[%0d]", z, rb), 32'(rbb[z]), 32'(m_busy(z, rb)));
      chk($sformatf("dut%0d pend_cnt", z), 32'(pc[z]), 32'(m_pend(z)));
    end
  end

  task automatic idle();
    we = 1'b0; ie = 1'b0; ce = 1'b0; call = 1'b0;
  endtask
  task automatic tick();
    @(posedge clk); #2;
  endtask
  task automatic mid();
    @(negedge clk); #1;
  endtask
  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d);
    we = 1'b1; wa = a; wd = d;
  endtask
  task automatic iss(input logic [AW-1:0] a);
    ie = 1'b1; ia = a;
  endtask

  initial begin
    // Reset, with a write presented that must neither bypass nor land.
    @(posedge clk); #2;
    ra = 3'd3; wr(3'd3, 16'hABCD);
    mid();
    chk("rst rd_data_a", 32'(rda[0]), 32'h0);
    chk("rst pend_cnt", 32'(pc[0]), 32'h0);
    chk("rst rd_busy_a", 32'(rba[0]), 32'h0);
    tick();
    rst = 1'b0; idle();
    mid();
    chk("write under rst ignored", 32'(rda[0]), 32'h0);

    // Bypass of r3 and persistence.
    tick(); wr(3'd3, 16'h1234); ra = 3'd3;
    mid(); chk("bypass r3", 32'(rda[0]), 32'h1234);
    tick(); idle();
    mid(); chk("stored r3", 32'(rda[0]), 32'h1234);

    // Issue r5, then write-back clears busy.
    tick(); iss(3'd5);
    tick(); idle(); rb = 3'd5;
    mid(); chk("busy r5", 32'(rbb[0]), 32'h1); chk("pend after iss r5", 32'(pc[0]), 32'h1);
    tick(); wr(3'd5, 16'h00AA);
    mid(); chk("busy r5 during wb", 32'(rbb[0]), 32'h0);
    tick(); idle();
    mid(); chk("pend after wb r5", 32'(pc[0]), 32'h0); chk("r5 data", 32'(rdb[0]), 32'h00AA);

    // Issue and write-back to r2 in the same cycle: issue wins busy.
    tick(); iss(3'd2); wr(3'd2, 16'h0F0F);
    tick(); idle(); ra = 3'd2;
    mid(); chk("r2 data", 32'(rda[0]), 32'h0F0F); chk("r2 busy", 32'(rba[0]), 32'h1);
    chk("pend r2", 32'(pc[0]), 32'h1);

    // Single clear beats write to the same register; clear-all empties everything.
    tick(); idle(); call = 1'b1;
    tick(); idle(); wr(3'd1, 16'h1111);
    tick(); wr(3'd4, 16'h4444);
    tick(); wr(3'd1, 16'h9999); ce = 1'b1; ca = 3'd1; ra = 3'd1;
    mid(); chk("clr+wr r1 bypass", 32'(rda[0]), 32'h0);
    tick(); idle(); ra = 3'd1; rb = 3'd4;
    mid(); chk("r1 cleared", 32'(rda[0]), 32'h0); chk("r4 kept", 32'(rdb[0]), 32'h4444);
    tick(); iss(3'd6);
    tick(); idle(); call = 1'b1;
    tick(); idle(); ra = 3'd4;
    mid(); chk("pend after clr_all", 32'(pc[0]), 32'h0); chk("r4 after clr_all", 32'(rda[0]), 32'h0);

    // Issue every register; ZERO_R0 build never marks r0.
    for (int i = 0; i < N; i++) begin
      tick(); idle(); iss(AW'(i));
    end
    tick(); idle();
    mid(); chk("pend all dut0", 32'(pc[0]), 32'h8); chk("pend all dut1", 32'(pc[1]), 32'h7);
    tick(); wr(3'd0, 16'hFFFF); ra = 3'd0;
    mid(); chk("r0 bypass dut0", 32'(rda[0]), 32'hFFFF); chk("r0 bypass dut1", 32'(rda[1]), 32'h0);
    tick(); idle();
    mid(); chk("r0 dut0", 32'(rda[0]), 32'hFFFF); chk("r0 dut1", 32'(rda[1]), 32'h0);
    chk("r0 busy dut1", 32'(rba[1]), 32'h0); chk("pend dut0 after r0 wb", 32'(pc[0]), 32'h7);

    // Asynchronous reset mid-cycle with r6 busy and holding data.
    tick(); call = 1'b1;
    tick(); idle(); iss(3'd6); wr(3'd6, 16'h6666);
    tick(); idle(); ra = 3'd6; rb = 3'd6;
    mid(); chk("r6 before rst", 32'(rda[0]), 32'h6666); chk("r6 busy before rst", 32'(rba[0]), 32'h1);
    #2 rst = 1'b1;
    #1;
    chk("async rst rd_data", 32'(rda[0]), 32'h0);
    chk("async rst rd_busy", 32'(rbb[0]), 32'h0);
    chk("async rst pend", 32'(pc[0]), 32'h0);
    wr(3'd6, 16'h7777);
    @(posedge clk); #2;
    rst = 1'b0; idle();
    mid(); chk("r6 write on rst edge ignored", 32'(rda[0]), 32'h0);

    // Randomized traffic checked by the per-cycle compare.
    for (int k = 0; k < 600; k++) begin
      tick();
      we   = ($urandom_range(1) == 1);
      wa   = AW'($urandom_range(N - 1));
      wd   = DW'($urandom);
      ie   = ($urandom_range(1) == 1);
      ia   = AW'($urandom_range(N - 1));
      ce   = ($urandom_range(3) == 0);
      ca   = AW'($urandom_range(N - 1));
      call = ($urandom_range(19) == 0);
      ra   = ($urandom_range(2) == 0) ? wa : AW'($urandom_range(N - 1));
      rb   = ($urandom_range(2) == 0) ? ia : AW'($urandom_range(N - 1));
    end
    tick(); idle();
    mid();

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
